// File: rtl/rf_lookup_cache_pkg.sv
// Shared types and helpers for the fully associative lookup cache.
// Optional statistics counters are enabled by RF_LOOKUP_CACHE_STATS_EN.
package rf_lookup_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MISS_REQ,
      MISS_WAIT,
      RESP
   } rf_lc_state_e;

   function automatic int lc_idx_w(input int entries);
      return $clog2(entries);
   endfunction

endpackage

// File: rtl/rf_lookup_cache_tags.sv
// Tag/value storage with parallel compare, first-invalid encoder and write port.
// Used by rf_lookup_cache (optional stats via RF_LOOKUP_CACHE_STATS_EN).
module rf_lookup_cache_tags
   import rf_lookup_cache_pkg::*;
#(
   parameter int KEY_W   = 32,
   parameter int VAL_W   = 32,
   parameter int ENTRIES = 8,
   parameter int IDX_W   = lc_idx_w(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] lookup_key,
   output logic             hit,
   output logic [VAL_W-1:0] hit_value,
   output logic             has_inv,
   output logic [IDX_W-1:0] inv_idx,
   input  logic             clr_all,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [KEY_W-1:0] wr_key,
   input  logic [VAL_W-1:0] wr_val
);

   logic [KEY_W-1:0]   key_q [ENTRIES];
   logic [KEY_W-1:0]   key_d [ENTRIES];
   logic [VAL_W-1:0]   val_q [ENTRIES];
   logic [VAL_W-1:0]   val_d [ENTRIES];
   logic [ENTRIES-1:0] vld_q;
   logic [ENTRIES-1:0] vld_d;

   // Keys are unique, so at most one entry can match.
   always_comb begin
      hit       = 1'b0;
      hit_value = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (vld_q[i] && key_q[i] == lookup_key) begin
            hit       = 1'b1;
            hit_value = val_q[i];
         end
      end
   end

   always_comb begin
      has_inv = 1'b0;
      inv_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!vld_q[i]) begin
            has_inv = 1'b1;
            inv_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      key_d = key_q;
      val_d = val_q;
      vld_d = vld_q;
      if (clr_all) begin
         vld_d = '0;
      end
      if (wr_en) begin
         key_d[wr_idx] = wr_key;
         val_d[wr_idx] = wr_val;
         vld_d[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            key_q[i] <= '0;
            val_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         key_q <= key_d;
         val_q <= val_d;
      end
   end

endmodule

// File: rtl/rf_lookup_cache.sv
// Fully associative lookup cache with miss fill, round-robin replacement and flush.
// Define RF_LOOKUP_CACHE_STATS_EN to add hit_count/miss_count outputs.
module rf_lookup_cache
   import rf_lookup_cache_pkg::*;
#(
   parameter int KEY_W   = 32,
   parameter int VAL_W   = 32,
   parameter int ENTRIES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [KEY_W-1:0] req_key,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [VAL_W-1:0] rsp_value,
   output logic             rsp_hit,
   output logic             fill_req_valid,
   input  logic             fill_req_ready,
   output logic [KEY_W-1:0] fill_req_key,
   input  logic             fill_rsp_valid,
   input  logic [VAL_W-1:0] fill_rsp_value,
   input  logic             flush
`ifdef RF_LOOKUP_CACHE_STATS_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
`endif
);

   localparam int IDX_W = lc_idx_w(ENTRIES);

   rf_lc_state_e     state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             fpend_q, fpend_d;
   logic [VAL_W-1:0] rsp_value_q, rsp_value_d;
   logic             rsp_hit_q, rsp_hit_d;
   logic [KEY_W-1:0] fill_key_q, fill_key_d;

   logic             hit;
   logic [VAL_W-1:0] hit_value;
   logic             has_inv;
   logic [IDX_W-1:0] inv_idx;
   logic             accept;
   logic             flush_apply;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;

   rf_lookup_cache_tags #(
      .KEY_W   (KEY_W),
      .VAL_W   (VAL_W),
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_tags (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_key (req_key),
      .hit        (hit),
      .hit_value  (hit_value),
      .has_inv    (has_inv),
      .inv_idx    (inv_idx),
      .clr_all    (flush_apply),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_key     (fill_key_q),
      .wr_val     (fill_rsp_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (accept) state_d = hit ? RESP : MISS_REQ;
         MISS_REQ:  if (fill_req_ready) state_d = MISS_WAIT;
         MISS_WAIT: if (fill_rsp_valid) state_d = RESP;
         RESP:      if (rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // A same-cycle flush pulse blocks acceptance so the flush is applied first.
   always_comb begin
      req_ready      = (state_q == IDLE) && !fpend_q && !flush;
      rsp_valid      = (state_q == RESP);
      fill_req_valid = (state_q == MISS_REQ);
      fill_req_key   = fill_key_q;
      rsp_value      = rsp_value_q;
      rsp_hit        = rsp_hit_q;
   end

   assign accept      = req_valid && req_ready;
   assign flush_apply = (state_q == IDLE) && fpend_q;
   assign wr_en       = (state_q == MISS_WAIT) && fill_rsp_valid;
   assign wr_idx      = has_inv ? inv_idx : ptr_q;

   always_comb begin
      ptr_d       = ptr_q;
      fpend_d     = (fpend_q && !flush_apply) || flush;
      rsp_value_d = rsp_value_q;
      rsp_hit_d   = rsp_hit_q;
      fill_key_d  = fill_key_q;
      if (flush_apply) begin
         ptr_d = '0;
      end
      if (accept && hit) begin
         rsp_value_d = hit_value;
         rsp_hit_d   = 1'b1;
      end
      if (accept && !hit) begin
         fill_key_d = req_key;
      end
      if (wr_en) begin
         rsp_value_d = fill_rsp_value;
         rsp_hit_d   = 1'b0;
         if (!has_inv) begin
            ptr_d = ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         fpend_q     <= 1'b0;
         rsp_value_q <= '0;
         rsp_hit_q   <= 1'b0;
         fill_key_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         fpend_q     <= fpend_d;
         rsp_value_q <= rsp_value_d;
         rsp_hit_q   <= rsp_hit_d;
         fill_key_q  <= fill_key_d;
      end
   end

`ifdef RF_LOOKUP_CACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rsp_valid && rsp_ready) begin
         if (rsp_hit_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
         if (!rsp_hit_q && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_rf_lookup_cache.sv
// Directed scoreboard bench for rf_lookup_cache with ENTRIES=4.
// Checks stats outputs when RF_LOOKUP_CACHE_STATS_EN is defined.
module tb_rf_lookup_cache;

   typedef struct {
      logic [31:0] val;
      logic        hit;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_key = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_value;
   logic        rsp_hit;
   logic        fill_req_valid;
   logic        fill_req_ready = 1'b0;
   logic [31:0] fill_req_key;
   logic        fill_rsp_valid = 1'b0;
   logic [31:0] fill_rsp_value = '0;
   logic        flush = 1'b0;
`ifdef RF_LOOKUP_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_hits = 0;
   int   m_miss = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   rf_lookup_cache #(
      .KEY_W   (32),
      .VAL_W   (32),
      .ENTRIES (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_key        (req_key),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_value      (rsp_value),
      .rsp_hit        (rsp_hit),
      .fill_req_valid (fill_req_valid),
      .fill_req_ready (fill_req_ready),
      .fill_req_key   (fill_req_key),
      .fill_rsp_valid (fill_rsp_valid),
      .fill_rsp_value (fill_rsp_value),
      .flush          (flush)
`ifdef RF_LOOKUP_CACHE_STATS_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   function automatic logic [31:0] backing(input logic [31:0] k);
      if (k == 32'h10) return 32'hAA;
      return (k * 32'h0101_0101) ^ 32'h5A00_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic [31:0] key, input bit exp_hit,
                         input int fill_stall, input int fill_delay,
                         input int rsp_stall, input bit flush_wait);
      exp_t e;
      int   n;
      logic [31:0] held;
      e.val = backing(key);
      e.hit = exp_hit;
      sb_q.push_back(e);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_key   = key;
      @(negedge clk);
      req_valid = 1'b0;
      chk("accept_next", {62'd0, rsp_valid, fill_req_valid},
          {62'd0, exp_hit, !exp_hit});
      if (!exp_hit) begin
         chk("fill_key", 64'(fill_req_key), 64'(key));
         for (int i = 0; i < fill_stall; i++) begin
            @(negedge clk);
            chk("fill_hold_v", 64'(fill_req_valid), 64'd1);
            chk("fill_hold_k", 64'(fill_req_key), 64'(key));
         end
         fill_req_ready = 1'b1;
         @(negedge clk);
         fill_req_ready = 1'b0;
         for (int i = 0; i < fill_delay; i++) begin
            flush = flush_wait && (i == 0);
            @(negedge clk);
            flush = 1'b0;
         end
         fill_rsp_valid = 1'b1;
         fill_rsp_value = backing(key);
         @(negedge clk);
         fill_rsp_valid = 1'b0;
         chk("miss_lat", 64'(rsp_valid), 64'd1);
      end
      held = rsp_value;
      for (int i = 0; i < rsp_stall; i++) begin
         @(negedge clk);
         chk("rsp_hold_v", 64'(rsp_valid), 64'd1);
         chk("rsp_hold_d", 64'(rsp_value), 64'(held));
         chk("rsp_hold_rdy", 64'(req_ready), 64'd0);
      end
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         chk("rsp_value", 64'(rsp_value), 64'(e.val));
         chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
         if (e.hit) m_hits++;
         else m_miss++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      // Reset values
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_value", 64'(rsp_value), 64'd0);
      chk("rst_rsp_hit", 64'(rsp_hit), 64'd0);
      chk("rst_fill_v", 64'(fill_req_valid), 64'd0);
      chk("rst_fill_k", 64'(fill_req_key), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Miss then hit
      do_req(32'h10, 1'b0, 0, 3, 0, 1'b0);
      do_req(32'h10, 1'b1, 0, 0, 0, 1'b0);

      // Flush in IDLE empties the cache
      flush = 1'b1;
      #1;
      chk("flush_same_rdy", 64'(req_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_apply_rdy", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("flush_done_rdy", 64'(req_ready), 64'd1);

      // Fill and replacement
      do_req(32'd1, 1'b0, 0, 1, 0, 1'b0);
      do_req(32'd2, 1'b0, 0, 1, 0, 1'b0);
      do_req(32'd3, 1'b0, 5, 1, 0, 1'b0);
      do_req(32'd4, 1'b0, 0, 2, 0, 1'b0);
      do_req(32'd5, 1'b0, 0, 1, 0, 1'b0);
      do_req(32'd2, 1'b1, 0, 0, 0, 1'b0);
      do_req(32'd3, 1'b1, 0, 0, 0, 1'b0);
      do_req(32'd4, 1'b1, 0, 0, 4, 1'b0);
      do_req(32'd1, 1'b0, 0, 1, 0, 1'b0);
      do_req(32'd5, 1'b1, 0, 0, 0, 1'b0);

      // Flush during MISS_WAIT
      do_req(32'd7, 1'b0, 0, 2, 0, 1'b1);
      chk("post_flush_rdy", 64'(req_ready), 64'd0);
      do_req(32'd7, 1'b0, 0, 1, 0, 1'b0);
      do_req(32'd7, 1'b1, 0, 0, 0, 1'b0);

      // Reset during MISS_REQ
      req_valid = 1'b1;
      req_key   = 32'h44;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mr_fill_v", 64'(fill_req_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_req_ready", 64'(req_ready), 64'd1);
      chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mr_rsp_value", 64'(rsp_value), 64'd0);
      chk("mr_rsp_hit", 64'(rsp_hit), 64'd0);
      chk("mr_fill_v0", 64'(fill_req_valid), 64'd0);
      chk("mr_fill_k", 64'(fill_req_key), 64'd0);
      m_hits = 0;
      m_miss = 0;
      @(negedge clk);
      rst_n = 1'b1;
      fill_rsp_valid = 1'b1;
      fill_rsp_value = 32'hDEAD;
      @(negedge clk);
      fill_rsp_valid = 1'b0;
      @(negedge clk);
      chk("mr_ign_valid", 64'(rsp_valid), 64'd0);
      chk("mr_ign_rdy", 64'(req_ready), 64'd1);

      // Earlier-cached key misses; 3 hits + 2 misses follow
      do_req(32'd7, 1'b0, 0, 1, 0, 1'b0);
      do_req(32'd7, 1'b1, 0, 0, 0, 1'b0);
      do_req(32'd7, 1'b1, 0, 0, 0, 1'b0);
      do_req(32'd8, 1'b0, 0, 2, 0, 1'b0);
      do_req(32'd8, 1'b1, 0, 0, 0, 1'b0);
`ifdef RF_LOOKUP_CACHE_STATS_EN
      chk("hit_count", 64'(hit_count), 64'(m_hits));
      chk("miss_count", 64'(miss_count), 64'(m_miss));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("hit_count_fl", 64'(hit_count), 64'd3);
      chk("miss_count_fl", 64'(miss_count), 64'd2);
`endif
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
